// File: rtl/uart_core_pkg.sv
// Shared frame constants and state encodings for the uart_core TX/RX paths.
package uart_core_pkg;
  localparam int   DATA_BITS            = 8;
  localparam logic START                = 1'b0;
  localparam logic STOP                 = 1'b1;
  localparam int   DEFAULT_CLKS_PER_BIT = 868;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
endpackage

// File: rtl/uart_core_fifo.sv
// Synchronous FIFO with a registered read port; occupancy flags decode an exact count register.
module uart_core_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_wr, do_rd;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign cnt   = count;

  // A write while full is dropped even if a read happens the same cycle.
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr];
      end
      count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
  end
endmodule

// File: rtl/uart_core.sv
// 8N1 UART: FIFO-fed transmitter plus independent receiver.
// UART_CORE_LOOPBACK_EN routes the internal tx into the receiver instead of the rx pin.
module uart_core
  import uart_core_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    wr_data,
  input  logic                          wr_en,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
  output logic                          tx,
  output logic                          is_transmitting,
  input  logic                          rx,
  output logic                          rx_valid,
  output logic [7:0]                    rx_byte,
  output logic                          is_receiving,
  output logic                          recv_error
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  logic [7:0] fifo_dout;
  logic       rd, rd_q, transmit;

  uart_core_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (rd),
    .rd_data (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .cnt     (fifo_cnt)
  );

  // rd_q blocks a second pop while the popped byte is still in flight to the FSM.
  assign rd       = !fifo_empty && !is_transmitting && !rd_q;
  assign transmit = rd_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_q <= 1'b0;
    else      rd_q <= rd;
  end

  tx_state_t     tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_sh;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state        <= TX_IDLE;
      tx_cnt          <= '0;
      tx_bit          <= '0;
      tx_sh           <= '0;
      tx              <= STOP;
      is_transmitting <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          tx              <= STOP;
          is_transmitting <= 1'b0;
          if (transmit) begin
            tx_state        <= TX_START;
            tx_sh           <= fifo_dout;
            tx_cnt          <= '0;
            tx              <= START;
            is_transmitting <= 1'b1;
          end
        end
        TX_START: begin
          if (tx_cnt == BIT_END) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx       <= tx_sh[0];
            tx_state <= TX_DATA;
          end else tx_cnt <= tx_cnt + 1'b1;
        end
        TX_DATA: begin
          if (tx_cnt == BIT_END) begin
            tx_cnt <= '0;
            if (tx_bit == LAST_BIT) begin
              tx       <= STOP;
              tx_state <= TX_STOP;
            end else begin
              tx_bit <= tx_bit + 1'b1;
              tx_sh  <= {1'b0, tx_sh[7:1]};
              tx     <= tx_sh[1];
            end
          end else tx_cnt <= tx_cnt + 1'b1;
        end
        TX_STOP: begin
          if (tx_cnt == BIT_END) begin
            tx_cnt          <= '0;
            tx_state        <= TX_IDLE;
            is_transmitting <= 1'b0;
          end else tx_cnt <= tx_cnt + 1'b1;
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  logic rx_in;
`ifdef UART_CORE_LOOPBACK_EN
  logic unused_rx;
  assign unused_rx = rx;
  assign rx_in     = tx;
`else
  assign rx_in = rx;
`endif

  logic [1:0]    rx_sync;
  logic          rx_s, armed;
  rx_state_t     rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_sh;

  assign rx_s = rx_sync[1];

  // Synchronizer resets to idle-high so reset release never looks like a start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rx_sync <= 2'b11;
    else      rx_sync <= {rx_sync[0], rx_in};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state     <= RX_IDLE;
      rx_cnt       <= '0;
      rx_bit       <= '0;
      rx_sh        <= '0;
      armed        <= 1'b0;
      rx_valid     <= 1'b0;
      recv_error   <= 1'b0;
      rx_byte      <= '0;
      is_receiving <= 1'b0;
    end else begin
      rx_valid   <= 1'b0;
      recv_error <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          // armed = line seen high since the last frame, so a low here is a falling edge
          if (rx_s) armed <= 1'b1;
          else if (armed) begin
            rx_state     <= RX_START;
            rx_cnt       <= '0;
            is_receiving <= 1'b1;
          end
        end
        RX_START: begin
          if (rx_cnt == HALF_END) begin
            rx_cnt <= '0;
            if (rx_s != START) begin
              rx_state     <= RX_IDLE;
              is_receiving <= 1'b0;
            end else begin
              rx_bit   <= '0;
              rx_state <= RX_DATA;
            end
          end else rx_cnt <= rx_cnt + 1'b1;
        end
        RX_DATA: begin
          if (rx_cnt == BIT_END) begin
            rx_cnt <= '0;
            rx_sh  <= {rx_s, rx_sh[7:1]};
            if (rx_bit == LAST_BIT) rx_state <= RX_STOP;
            else                    rx_bit   <= rx_bit + 1'b1;
          end else rx_cnt <= rx_cnt + 1'b1;
        end
        RX_STOP: begin
          if (rx_cnt == BIT_END) begin
            rx_cnt       <= '0;
            rx_state     <= RX_IDLE;
            is_receiving <= 1'b0;
            armed        <= 1'b0;
            if (rx_s == STOP) begin
              rx_valid <= 1'b1;
              rx_byte  <= rx_sh;
            end else recv_error <= 1'b1;
          end else rx_cnt <= rx_cnt + 1'b1;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_core.sv
// Scoreboard bench for uart_core: stimulus pushes expected frames/events, monitors pop and compare.
module tb_uart_core;
  localparam int CPB   = 4;
  localparam int DEPTH = 16;
  localparam int CNTW  = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [7:0]      wr_data = '0;
  logic            wr_en = 1'b0;
  logic            fifo_full, fifo_empty;
  logic [CNTW-1:0] fifo_cnt;
  logic            tx, is_transmitting;
  logic            rx = 1'b1;
  logic            rx_valid, is_receiving, recv_error;
  logic [7:0]      rx_byte;

  uart_core #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .wr_data         (wr_data),
    .wr_en           (wr_en),
    .fifo_full       (fifo_full),
    .fifo_empty      (fifo_empty),
    .fifo_cnt        (fifo_cnt),
    .tx              (tx),
    .is_transmitting (is_transmitting),
    .rx              (rx),
    .rx_valid        (rx_valid),
    .rx_byte         (rx_byte),
    .is_receiving    (is_receiving),
    .recv_error      (recv_error)
  );

  always #5 clk = ~clk;

  typedef struct {logic err; logic [7:0] data;} rx_exp_t;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic       gap_en = 1'b0;
  logic [7:0] tx_q[$];
  rx_exp_t    rx_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_tx(input logic [7:0] b);
    rx_exp_t e;
    tx_q.push_back(b);
`ifdef UART_CORE_LOOPBACK_EN
    e.err = 1'b0; e.data = b;
    rx_q.push_back(e);
`endif
  endtask

  task automatic push_rx(input logic err, input logic [7:0] b);
    rx_exp_t e;
    e.err = err; e.data = b;
    rx_q.push_back(e);
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++)
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        rx = f[k];
        if (k == 5 && c == 0) check("is_receiving_mid", is_receiving, 1);
      end
    @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic wait_empty(input int budget);
    int n = 0;
    while ((tx_q.size() != 0 || rx_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  // TX monitor: decodes every frame on tx, checks bit stability, busy flag, byte order and gaps.
  initial begin
    int         start, last_start;
    logic       have_last, aborted, stable, busy_ok;
    logic [9:0] fr;
    have_last = 1'b0;
    last_start = 0;
    forever begin
      @(negedge clk);
      if (!gap_en) have_last = 1'b0;
      if (rst && !tx) begin
        start = cyc; aborted = 1'b0; stable = 1'b1; busy_ok = 1'b1; fr = '0;
        for (int k = 0; k < 10 * CPB; k++) begin
          if (k > 0) @(negedge clk);
          if (!rst) begin aborted = 1'b1; break; end
          if (k % CPB == 0) fr[k / CPB] = tx;
          else if (tx !== fr[k / CPB]) stable = 1'b0;
          if (!is_transmitting) busy_ok = 1'b0;
        end
        if (!aborted) begin
          @(negedge clk);
          check("tx_bit_stable", stable, 1);
          check("tx_busy_in_frame", busy_ok, 1);
          check("tx_start_bit", fr[0], 0);
          check("tx_stop_bit", fr[9], 1);
          check("tx_busy_after", is_transmitting, 0);
          if (tx_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL tx_unexpected_frame: got %0h expected none", fr[8:1]);
          end else check("tx_byte", fr[8:1], tx_q.pop_front());
          if (gap_en && have_last) check("tx_frame_spacing", start - last_start, 10 * CPB + 2);
          last_start = start;
          have_last  = gap_en;
        end
      end
    end
  end

  // RX monitor: every valid/error pulse must match the next queued expectation.
  initial begin
    rx_exp_t e;
    forever begin
      @(negedge clk);
      if (rx_valid || recv_error) begin
        if (rx_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rx_unexpected_pulse: got valid=%0b err=%0b expected none", rx_valid, recv_error);
        end else begin
          e = rx_q.pop_front();
          check("rx_kind", {rx_valid, recv_error}, e.err ? 2'b01 : 2'b10);
          check("rx_byte", rx_byte, e.data);
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", is_transmitting, 0);
    check("rst_empty", fifo_empty, 1);
    check("rst_full", fifo_full, 0);
    check("rst_cnt", fifo_cnt, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_byte", rx_byte, 0);
    check("rst_receiving", is_receiving, 0);
    check("rst_recv_error", recv_error, 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // single byte: tx falls on the third sample after the write strobe
    wr_en = 1'b1; wr_data = 8'hA5; push_tx(8'hA5);
    @(negedge clk); wr_en = 1'b0;
    check("wr_cnt_inc", fifo_cnt, 1);
    check("wr_empty_fall", fifo_empty, 0);
    check("lat_tx_idle1", tx, 1);
    @(negedge clk);
    check("lat_tx_idle2", tx, 1);
    @(negedge clk);
    check("lat_tx_start", tx, 0);
    check("lat_busy", is_transmitting, 1);
    repeat (50) @(negedge clk);

    // burst of 20: 0x00 is popped at once, 0x01..0x10 fill the FIFO, 0x11..0x13 drop
    gap_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      wr_en = 1'b1; wr_data = 8'(i);
      if (i <= 16) push_tx(8'(i));
    end
    @(negedge clk); wr_en = 1'b0;
    check("burst_full", fifo_full, 1);
    check("burst_cnt", fifo_cnt, 16);
    wait_empty(2000);
    check("burst_drained", tx_q.size(), 0);
    repeat (5) @(negedge clk);
    gap_en = 1'b0;

    // reset mid-frame discards the frame and the FIFO contents
    wr_en = 1'b1; wr_data = 8'h77;
    @(negedge clk); wr_data = 8'h12;
    @(negedge clk); wr_en = 1'b0;
    repeat (15) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_tx", tx, 1);
    check("midrst_cnt", fifo_cnt, 0);
    check("midrst_empty", fifo_empty, 1);
    check("midrst_busy", is_transmitting, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (60) @(negedge clk);
    check("postrst_idle", tx, 1);

`ifndef UART_CORE_LOOPBACK_EN
    push_rx(1'b0, 8'h3C);
    drive_frame(8'h3C, 1'b1);
    repeat (4) @(negedge clk);
    check("is_receiving_after", is_receiving, 0);
    repeat (10) @(negedge clk);

    // bad stop bit: error pulse, rx_byte keeps the previous byte
    push_rx(1'b1, 8'h3C);
    drive_frame(8'h55, 1'b0);
    repeat (10) @(negedge clk);

    @(negedge clk); rx = 1'b0;
    @(negedge clk); rx = 1'b1;
    repeat (60) @(negedge clk);
    check("glitch_byte_kept", rx_byte, 8'h3C);
`else
    @(negedge clk); wr_en = 1'b1; wr_data = 8'h81; push_tx(8'h81);
    @(negedge clk); wr_en = 1'b0;
    repeat (60) @(negedge clk);
    check("loop_byte", rx_byte, 8'h81);
`endif

    wait_empty(1000);
    check("tx_queue_empty", tx_q.size(), 0);
    check("rx_queue_empty", rx_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
